regfile_wb_arbiter: RTL and testbench

- Owns the single register-file write port (WE/AddD/DataD) and shares it between two writers.
  - Requester 0: core writeback.
  - Requester 1: debug/loader unit that lets the GUI write registers at runtime.
- After reset it optionally scrubs x1..x31 to a known value before granting anyone.
- Sits between the writeback stage/debug unit and the register file. Outputs are registered and drive the register-file write inputs directly.

---
 rtl/rv32i_pkg.sv | 14 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: arbiter state encoding, register-file geometry, requester IDs.
package rv32i_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_XREGS  = 32;

    localparam logic SCRUB = 1'b0;
    localparam logic RUN   = 1'b1;

    localparam int unsigned REQ_CORE = 0;
    localparam int unsigned REQ_DBG  = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic: fixed priority (req[0] wins) or round-robin with a pointer flop.
module rr_arb2 #(
    parameter bit RR_MODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && req[1]) begin
                gnt = (RR_MODE && ptr_q) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Pointer names the favoured requester; after any grant favour the other one.
    always_comb begin
        ptr_d = ptr_q;
        if (RR_MODE && (gnt != 2'b00)) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: post-reset scrub of x1..x31, then core/debug arbitration.
// Optional RF_WB_CONFLICT_CNT_EN adds conflict_cnt and last_loser outputs.
module regfile_wb_arbiter #(
    parameter int unsigned     XLEN        = 32,
    parameter bit              SCRUB_EN    = 1'b1,
    parameter logic [XLEN-1:0] SCRUB_VALUE = '0,
    parameter bit              RR_MODE     = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [4:0]      req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            rf_we,
    output logic [4:0]      rf_addd,
    output logic [XLEN-1:0] rf_datad,
`ifdef RF_WB_CONFLICT_CNT_EN
    output logic [15:0]     conflict_cnt,
    output logic            last_loser,
`endif
    output logic            init_done
);

    import rv32i_pkg::*;

    logic                  state_q, state_d;
    logic [REG_ADDR_W-1:0] idx_q, idx_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_addd_q, rf_addd_d;
    logic [XLEN-1:0]       rf_datad_q, rf_datad_d;
    logic                  init_done_q, init_done_d;
    logic                  live;
    logic [1:0]            gnt;

    // init_done_q keeps readys low for the first cycle out of reset even when scrub is skipped.
    assign live = (state_q == RUN) && init_done_q;

    rr_arb2 #(
        .RR_MODE (RR_MODE)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (live),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[REQ_CORE];
    assign req1_ready = gnt[REQ_DBG];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rf_we_d    = 1'b0;
        rf_addd_d  = rf_addd_q;
        rf_datad_d = rf_datad_q;
        case (state_q)
            SCRUB: begin
                // idx wraps 31 -> 0 after the last write; 0 marks the cycle before RUN.
                if (idx_q != '0) begin
                    rf_we_d    = 1'b1;
                    rf_addd_d  = idx_q;
                    rf_datad_d = SCRUB_VALUE;
                    idx_d      = idx_q + 5'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                if (gnt[REQ_CORE]) begin
                    rf_we_d    = (req0_addr != 5'd0);
                    rf_addd_d  = req0_addr;
                    rf_datad_d = req0_data;
                end else if (gnt[REQ_DBG]) begin
                    rf_we_d    = (req1_addr != 5'd0);
                    rf_addd_d  = req1_addr;
                    rf_datad_d = req1_data;
                end
            end
        endcase
        init_done_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SCRUB_EN ? SCRUB : RUN;
            idx_q       <= 5'd1;
            rf_we_q     <= 1'b0;
            rf_addd_q   <= '0;
            rf_datad_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rf_we_q     <= rf_we_d;
            rf_addd_q   <= rf_addd_d;
            rf_datad_q  <= rf_datad_d;
            init_done_q <= init_done_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_addd   = rf_addd_q;
    assign rf_datad  = rf_datad_q;
    assign init_done = init_done_q;

`ifdef RF_WB_CONFLICT_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        loser_q, loser_d;

    always_comb begin
        cnt_d   = cnt_q;
        loser_d = loser_q;
        if (live && req0_valid && req1_valid) begin
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
            // Core granted means debug lost, and vice versa.
            loser_d = gnt[REQ_CORE];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            loser_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            loser_q <= loser_d;
        end
    end

    assign conflict_cnt = cnt_q;
    assign last_loser   = loser_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: fixed-priority and round-robin instances share stimulus
// and are compared every cycle against a cycle-count/queue-level model plus literal pins.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    logic        r0r [2];
    logic        r1r [2];
    logic        we  [2];
    logic [4:0]  ad  [2];
    logic [31:0] dd  [2];
    logic        idn [2];
`ifdef RF_WB_CONFLICT_CNT_EN
    logic [15:0] cc  [2];
    logic        ll  [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(
        .XLEN(32), .SCRUB_EN(1'b1), .SCRUB_VALUE(32'hDEADBEEF), .RR_MODE(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0r[0]),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1r[0]),
        .rf_we(we[0]), .rf_addd(ad[0]), .rf_datad(dd[0]),
`ifdef RF_WB_CONFLICT_CNT_EN
        .conflict_cnt(cc[0]), .last_loser(ll[0]),
`endif
        .init_done(idn[0])
    );

    regfile_wb_arbiter #(
        .XLEN(32), .SCRUB_EN(1'b1), .SCRUB_VALUE(32'h00000000), .RR_MODE(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0r[1]),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1r[1]),
        .rf_we(we[1]), .rf_addd(ad[1]), .rf_datad(dd[1]),
`ifdef RF_WB_CONFLICT_CNT_EN
        .conflict_cnt(cc[1]), .last_loser(ll[1]),
`endif
        .init_done(idn[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    // Model: k counts cycles since reset release; cycles 1..31 are scrub writes and
    // arbitration is live from cycle 32. Expected outputs for the next cycle are staged here.
    bit          rr_of [2] = '{1'b0, 1'b1};
    logic [31:0] sv_of [2] = '{32'hDEADBEEF, 32'h00000000};
    int          k     [2];
    int          ptr   [2];
    bit          e_we  [2];
    logic [4:0]  e_ad  [2];
    logic [31:0] e_dd  [2];
    int          e_cc  [2];
    int          e_ll  [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                k[i] = 0; ptr[i] = 0; e_we[i] = 1'b0; e_cc[i] = 0; e_ll[i] = 0;
                chk("reset_we", i, 32'(we[i]), 0);
                chk("reset_addd", i, 32'(ad[i]), 0);
                chk("reset_datad", i, dd[i], 0);
                chk("reset_ready0", i, 32'(r0r[i]), 0);
                chk("reset_ready1", i, 32'(r1r[i]), 0);
                chk("reset_init_done", i, 32'(idn[i]), 0);
`ifdef RF_WB_CONFLICT_CNT_EN
                chk("reset_conflict_cnt", i, 32'(cc[i]), 0);
                chk("reset_last_loser", i, 32'(ll[i]), 0);
`endif
            end else begin
                int  winner;
                bit  live;
                live = (k[i] >= 32);
                winner = -1;
                if (live) begin
                    if (v0 && v1)  winner = rr_of[i] ? ptr[i] : 0;
                    else if (v0)   winner = 0;
                    else if (v1)   winner = 1;
                end
                chk("ready0", i, 32'(r0r[i]), (winner == 0) ? 1 : 0);
                chk("ready1", i, 32'(r1r[i]), (winner == 1) ? 1 : 0);
                chk("init_done", i, 32'(idn[i]), live ? 1 : 0);
                chk("rf_we", i, 32'(we[i]), 32'(e_we[i]));
                if (e_we[i]) begin
                    chk("rf_addd", i, 32'(ad[i]), 32'(e_ad[i]));
                    chk("rf_datad", i, dd[i], e_dd[i]);
                end
`ifdef RF_WB_CONFLICT_CNT_EN
                chk("conflict_cnt", i, 32'(cc[i]), e_cc[i]);
                chk("last_loser", i, 32'(ll[i]), e_ll[i]);
`endif
                if (k[i] + 1 <= 31) begin
                    e_we[i] = 1'b1;
                    e_ad[i] = 5'(k[i] + 1);
                    e_dd[i] = sv_of[i];
                end else if (winner >= 0) begin
                    e_ad[i] = (winner == 0) ? a0 : a1;
                    e_dd[i] = (winner == 0) ? d0 : d1;
                    e_we[i] = (e_ad[i] != 5'd0);
                    if (rr_of[i]) ptr[i] = 1 - winner;
                end else begin
                    e_we[i] = 1'b0;
                end
                if (live && v0 && v1) begin
                    if (e_cc[i] < 65535) e_cc[i]++;
                    e_ll[i] = 1 - winner;
                end
                k[i]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic sv0, input logic [4:0] sa0, input logic [31:0] sd0,
                           input logic sv1, input logic [4:0] sa1, input logic [31:0] sd1);
        v0 = sv0; a0 = sa0; d0 = sd0;
        v1 = sv1; a1 = sa1; d1 = sd1;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        v0 = 1'b0; a0 = '0; d0 = '0;
        v1 = 1'b0; a1 = '0; d1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // First scrub, aborted asynchronously at index 17.
        repeat (17) @(posedge clk);
        #3;
        chk("scrub_idx17_addd", 0, 32'(ad[0]), 17);
        chk("scrub_idx17_we", 0, 32'(we[0]), 1);
        rst = 1'b0;
        #1;
        chk("async_reset_we", 0, 32'(we[0]), 0);
        chk("async_reset_we", 1, 32'(we[1]), 0);
        chk("async_reset_addd", 0, 32'(ad[0]), 0);

        // Restart; both requesters wait through the whole scrub.
        @(posedge clk);
        #1 rst = 1'b1;
        set_req(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
        repeat (31) tick();
        chk("scrub_last_addd", 0, 32'(ad[0]), 31);
        chk("scrub_last_datad", 0, dd[0], 32'hDEADBEEF);
        chk("scrub_last_datad", 1, dd[1], 32'h0);
        chk("scrub_init_low", 0, 32'(idn[0]), 0);
        chk("scrub_ready0_low", 0, 32'(r0r[0]), 0);

        tick();                                            // cycle 32
        chk("init_done_c32", 0, 32'(idn[0]), 1);
        chk("idle_we_c32", 0, 32'(we[0]), 0);
        chk("fixed_ready0_c32", 0, 32'(r0r[0]), 1);
        chk("fixed_ready1_c32", 0, 32'(r1r[0]), 0);
        chk("rr_ready0_c32", 1, 32'(r0r[1]), 1);
        tick();                                            // cycle 33
        chk("fixed_write_addd", 0, 32'(ad[0]), 5);
        chk("fixed_write_datad", 0, dd[0], 32'h11);
        chk("rr_ready1_c33", 1, 32'(r1r[1]), 1);
        tick();                                            // cycle 34
        tick();                                            // cycle 35
        set_req(1'b0, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
        chk("fixed_lone_ready1", 0, 32'(r1r[0]), 1);

        tick();                                            // cycle 36: round-robin run
        set_req(1'b1, 5'd7, 32'h33, 1'b1, 5'd8, 32'h44);
        chk("fixed_req1_addd", 0, 32'(ad[0]), 6);
        chk("fixed_req1_datad", 0, dd[0], 32'h22);
        chk("rr_ready0_c36", 1, 32'(r0r[1]), 1);
        tick();
        chk("rr_ready1_c37", 1, 32'(r1r[1]), 1);
        chk("rr_addd_c37", 1, 32'(ad[1]), 7);
        tick();
        chk("rr_ready0_c38", 1, 32'(r0r[1]), 1);
        chk("rr_addd_c38", 1, 32'(ad[1]), 8);
        tick();
        chk("rr_ready1_c39", 1, 32'(r1r[1]), 1);
        chk("rr_addd_c39", 1, 32'(ad[1]), 7);

        tick();                                            // cycle 40: x0 discard
        set_req(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
        chk("x0_ready1", 0, 32'(r1r[0]), 1);
        chk("x0_ready1", 1, 32'(r1r[1]), 1);
        tick();                                            // cycle 41
        set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("x0_no_write", 0, 32'(we[0]), 0);
        chk("x0_no_write", 1, 32'(we[1]), 0);

        tick();                                            // cycle 42: same-address collision
        set_req(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 32'h66);
        tick();
        set_req(1'b0, 5'd9, 32'h55, 1'b1, 5'd9, 32'h66);
        chk("same_addr_winner", 0, dd[0], 32'h55);
        tick();
        set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("same_addr_overwrite", 0, dd[0], 32'h66);
        chk("same_addr_overwrite_addd", 0, 32'(ad[0]), 9);
`ifdef RF_WB_CONFLICT_CNT_EN
        chk("conflict_cnt_total", 0, 32'(cc[0]), 8);
        chk("last_loser_fixed", 0, 32'(ll[0]), 1);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
